// File: rtl/rom_arb_pkg.sv
// Shared definitions for the two-requester ROM arbiter: FSM encodings,
// default geometry and requester ids.
package rom_arb_pkg;

  localparam int unsigned DEF_ADDR_W = 4;
  localparam int unsigned DEF_DATA_W = 10;
  localparam int unsigned DEF_DEPTH  = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic REQ0 = 1'b0;
  localparam logic REQ1 = 1'b1;

endpackage

// File: rtl/rom_arbiter_if.sv
// Bus bundle for rom_arbiter: two request/response channels plus the ROM port.
// slave is the arbiter side, master is the requester/ROM side.
interface rom_arbiter_if #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 10
);

  logic              req0_valid;
  logic [ADDR_W-1:0] req0_addr;
  logic              req0_ready;
  logic              rsp0_valid;
  logic              rsp0_ready;
  logic [DATA_W-1:0] rsp0_data;
  logic              rsp0_err;

  logic              req1_valid;
  logic [ADDR_W-1:0] req1_addr;
  logic              req1_ready;
  logic              rsp1_valid;
  logic              rsp1_ready;
  logic [DATA_W-1:0] rsp1_data;
  logic              rsp1_err;

  logic              rom_cs;
  logic [ADDR_W-1:0] rom_addr;
  logic [DATA_W-1:0] rom_data;

  modport slave (
    input  req0_valid, req0_addr, rsp0_ready,
    input  req1_valid, req1_addr, rsp1_ready,
    input  rom_data,
    output req0_ready, rsp0_valid, rsp0_data, rsp0_err,
    output req1_ready, rsp1_valid, rsp1_data, rsp1_err,
    output rom_cs, rom_addr
  );

  modport master (
    output req0_valid, req0_addr, rsp0_ready,
    output req1_valid, req1_addr, rsp1_ready,
    output rom_data,
    input  req0_ready, rsp0_valid, rsp0_data, rsp0_err,
    input  req1_ready, rsp1_valid, rsp1_data, rsp1_err,
    input  rom_cs, rom_addr
  );

endinterface

// File: rtl/rom_arb_grant.sv
// Combinational grant selection between two requesters.
// Macro ROM_ARB_RR_EN: defined -> round-robin on contest (grant the requester
// other than the last grant); undefined -> fixed priority, requester 0 wins.
module rom_arb_grant
  import rom_arb_pkg::*;
(
  input  logic i_valid0,
  input  logic i_valid1,
  input  logic i_last,
  output logic o_any,
  output logic o_grant
);

`ifndef ROM_ARB_RR_EN
  // Pointer is kept by the parent but plays no part in fixed priority.
  logic w_unused_last;
  assign w_unused_last = i_last;
`endif

  // Pick the winner; requester 0 is the default when nobody contends.
  always_comb begin
    o_any   = i_valid0 | i_valid1;
    o_grant = REQ0;
`ifdef ROM_ARB_RR_EN
    if (i_valid0 && i_valid1) begin
      o_grant = ~i_last;
    end else if (i_valid1) begin
      o_grant = REQ1;
    end
`else
    if (!i_valid0 && i_valid1) begin
      o_grant = REQ1;
    end
`endif
  end

endmodule

// File: rtl/rom_arbiter.sv
// Shares a small asynchronous-read ROM between two valid/ready requesters.
// One transaction in flight: IDLE accepts, READ strobes the ROM for one cycle,
// RESP holds the response until the granted requester consumes it.
// Out-of-range addresses skip READ and return err=1, data=0.
// Macro ROM_ARB_RR_EN (see rom_arb_grant) selects round-robin arbitration.
module rom_arbiter
  import rom_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = rom_arb_pkg::DEF_ADDR_W,
  parameter int unsigned DATA_W = rom_arb_pkg::DEF_DATA_W,
  parameter int unsigned DEPTH  = rom_arb_pkg::DEF_DEPTH
) (
  input  logic         clk,
  input  logic         rst_n,
  rom_arbiter_if.slave bus
);

  localparam logic [ADDR_W:0] LP_DEPTH = (ADDR_W + 1)'(DEPTH);

  state_t            r_state, w_state_d;
  logic              r_last, w_last_d;
  logic              r_gnt, w_gnt_d;
  logic              r_rom_cs, w_rom_cs_d;
  logic [ADDR_W-1:0] r_rom_addr, w_rom_addr_d;
  logic [DATA_W-1:0] r_data0, w_data0_d;
  logic [DATA_W-1:0] r_data1, w_data1_d;
  logic              r_err0, w_err0_d;
  logic              r_err1, w_err1_d;

  logic              w_any;
  logic              w_grant;
  logic              w_req_ready;
  logic [ADDR_W-1:0] w_sel_addr;
  logic              w_in_range;
  logic              w_rsp_ready;

  rom_arb_grant u_grant (
    .i_valid0 (bus.req0_valid),
    .i_valid1 (bus.req1_valid),
    .i_last   (r_last),
    .o_any    (w_any),
    .o_grant  (w_grant)
  );

  // Request side is ready only in IDLE; gated by rst_n so ready is 0 in reset.
  assign w_req_ready = rst_n && (r_state == IDLE) && w_any;
  assign w_sel_addr  = (w_grant == REQ0) ? bus.req0_addr : bus.req1_addr;
  assign w_in_range  = ({1'b0, w_sel_addr} < LP_DEPTH);
  assign w_rsp_ready = (r_gnt == REQ0) ? bus.rsp0_ready : bus.rsp1_ready;

  assign bus.req0_ready = w_req_ready && (w_grant == REQ0);
  assign bus.req1_ready = w_req_ready && (w_grant == REQ1);
  assign bus.rsp0_valid = (r_state == RESP) && (r_gnt == REQ0);
  assign bus.rsp1_valid = (r_state == RESP) && (r_gnt == REQ1);
  assign bus.rsp0_data  = r_data0;
  assign bus.rsp1_data  = r_data1;
  assign bus.rsp0_err   = r_err0;
  assign bus.rsp1_err   = r_err1;
  assign bus.rom_cs     = r_rom_cs;
  assign bus.rom_addr   = r_rom_addr;

  // Next-state and next-register values; ROM strobe defaults low.
  always_comb begin
    w_state_d    = r_state;
    w_last_d     = r_last;
    w_gnt_d      = r_gnt;
    w_rom_cs_d   = 1'b0;
    w_rom_addr_d = '0;
    w_data0_d    = r_data0;
    w_data1_d    = r_data1;
    w_err0_d     = r_err0;
    w_err1_d     = r_err1;

    case (r_state)
      IDLE: begin
        if (w_req_ready) begin
          w_gnt_d  = w_grant;
          w_last_d = w_grant;
          if (w_in_range) begin
            // rom_cs/rom_addr are registered so they are live during READ.
            w_state_d    = READ;
            w_rom_cs_d   = 1'b1;
            w_rom_addr_d = w_sel_addr;
          end else begin
            w_state_d = RESP;
            if (w_grant == REQ0) begin
              w_data0_d = '0;
              w_err0_d  = 1'b1;
            end else begin
              w_data1_d = '0;
              w_err1_d  = 1'b1;
            end
          end
        end
      end
      READ: begin
        w_state_d = RESP;
        if (r_gnt == REQ0) begin
          w_data0_d = bus.rom_data;
          w_err0_d  = 1'b0;
        end else begin
          w_data1_d = bus.rom_data;
          w_err1_d  = 1'b0;
        end
      end
      RESP: begin
        if (w_rsp_ready) begin
          w_state_d = IDLE;
        end
      end
      default: begin
        w_state_d = IDLE;
      end
    endcase
  end

  // State and response registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state    <= IDLE;
      r_last     <= REQ1;
      r_gnt      <= REQ0;
      r_rom_cs   <= 1'b0;
      r_rom_addr <= '0;
      r_data0    <= '0;
      r_data1    <= '0;
      r_err0     <= 1'b0;
      r_err1     <= 1'b0;
    end else begin
      r_state    <= w_state_d;
      r_last     <= w_last_d;
      r_gnt      <= w_gnt_d;
      r_rom_cs   <= w_rom_cs_d;
      r_rom_addr <= w_rom_addr_d;
      r_data0    <= w_data0_d;
      r_data1    <= w_data1_d;
      r_err0     <= w_err0_d;
      r_err1     <= w_err1_d;
    end
  end

endmodule
